// File: rtl/req_traffic_gen_pkg.sv
// Shared types and constants for the request-traffic generator and its per-client FSMs.
package req_traffic_gen_pkg;

    typedef enum logic [1:0] {IDLE, REQ, BUSY, REL} client_state_e;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    localparam int          HOLD_MAX_DEF  = 14;
    localparam int          IDLE_MAX_DEF  = 15;

    // One step of the 16-bit right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/req_traffic_gen_client.sv
// One requester: idle countdown, request until granted, hold for hold_len cycles,
// pulse release, then idle again. Also keeps a saturating service count and a sticky error flag.
module req_client_fsm
    import req_traffic_gen_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int STAT_W = 8,
    parameter int IDX    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              grant,
    input  logic [CNT_W-1:0]  hold_len,
    input  logic [CNT_W-1:0]  idle_len,
    output logic              request,
    output logic              release_pulse,
    output logic              busy,
    output logic              proto_err,
    output logic [STAT_W-1:0] served_cnt
);

    client_state_e    state;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             after_rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idle_cnt      <= CNT_W'(IDX);
            hold_cnt      <= '0;
            after_rel     <= 1'b0;
            request       <= 1'b0;
            release_pulse <= 1'b0;
            busy          <= 1'b0;
            proto_err     <= 1'b0;
            served_cnt    <= '0;
        end else begin
            after_rel <= 1'b0;
            case (state)
                IDLE: begin
                    // The arbiter may lag by one cycle in dropping grant after a release.
                    if (grant && !after_rel)
                        proto_err <= 1'b1;
                    if (enable) begin
                        if (idle_cnt == '0) begin
                            state   <= REQ;
                            request <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt - 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (grant) begin
                        state    <= BUSY;
                        request  <= 1'b0;
                        busy     <= 1'b1;
                        hold_cnt <= hold_len;
                    end
                end
                BUSY: begin
                    if (!grant) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        proto_err <= 1'b1;
                        idle_cnt  <= idle_len;
                    end else if (hold_cnt == CNT_W'(1)) begin
                        state         <= REL;
                        busy          <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                REL: begin
                    state         <= IDLE;
                    release_pulse <= 1'b0;
                    idle_cnt      <= idle_len;
                    after_rel     <= 1'b1;
                    if (served_cnt != '1)
                        served_cnt <= served_cnt + 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/req_traffic_gen.sv
// Reproducible request traffic for the arbiter: a shared LFSR (or fixed config)
// supplies hold/idle lengths to N_CLIENTS independent request FSMs.
module req_traffic_gen
    import req_traffic_gen_pkg::*;
#(
    parameter int          N_CLIENTS = 3,
    parameter int          CNT_W     = 4,
    parameter int          HOLD_MAX  = HOLD_MAX_DEF,
    parameter int          IDLE_MAX  = IDLE_MAX_DEF,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter int          STAT_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        cfg_fixed,
    input  logic [CNT_W-1:0]            cfg_hold,
    input  logic [CNT_W-1:0]            cfg_idle,
    input  logic [N_CLIENTS-1:0]        grant,
    output logic [N_CLIENTS-1:0]        request,
    output logic [N_CLIENTS-1:0]        release_pulse,
    output logic [N_CLIENTS-1:0]        busy,
    output logic [N_CLIENTS-1:0]        proto_err,
    output logic [N_CLIENTS*STAT_W-1:0] served_cnt
);

    logic [15:0] lfsr;

    // Free-running so the random sequence depends only on time since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_step(lfsr);
    end

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_client
        logic [3:0]       field;
        logic [CNT_W-1:0] hold_len;
        logic [CNT_W-1:0] idle_len;

        assign field = lfsr[4*i +: 4];

        always_comb begin
            if (cfg_fixed) begin
                hold_len = (cfg_hold == '0) ? CNT_W'(1) : cfg_hold;
                idle_len = cfg_idle;
            end else begin
                hold_len = CNT_W'(32'(field) % HOLD_MAX + 1);
                idle_len = CNT_W'(32'(field) % IDLE_MAX);
            end
        end

        req_client_fsm #(
            .CNT_W (CNT_W),
            .STAT_W(STAT_W),
            .IDX   (i)
        ) u_client (
            .clk          (clk),
            .rst_n        (rst_n),
            .enable       (enable),
            .grant        (grant[i]),
            .hold_len     (hold_len),
            .idle_len     (idle_len),
            .request      (request[i]),
            .release_pulse(release_pulse[i]),
            .busy         (busy[i]),
            .proto_err    (proto_err[i]),
            .served_cnt   (served_cnt[i*STAT_W +: STAT_W])
        );
    end

endmodule

// File: tb/tb_req_traffic_gen.sv
// Randomized and directed bench for req_traffic_gen against a cycle-level behavioural model.
module tb_req_traffic_gen;

    localparam int N  = 3;
    localparam int HM = 14;
    localparam int IM = 15;
    localparam int TR = 300;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b1;
    logic         cfg_fixed = 1'b1;
    logic [3:0]   cfg_hold = 4'd3;
    logic [3:0]   cfg_idle = 4'd2;
    logic [N-1:0] grant = '0;
    logic [N-1:0] request, release_pulse, busy, proto_err;
    logic [23:0]  served_cnt;

    always #5 clk = ~clk;

    req_traffic_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_fixed    (cfg_fixed),
        .cfg_hold     (cfg_hold),
        .cfg_idle     (cfg_idle),
        .grant        (grant),
        .request      (request),
        .release_pulse(release_pulse),
        .busy         (busy),
        .proto_err    (proto_err),
        .served_cnt   (served_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_on = 0;

    // Model: expected outputs for the current cycle plus per-client bookkeeping.
    logic [15:0]  m_lfsr;
    logic [N-1:0] m_req, m_busy, m_rel, m_err, m_grace;
    int           m_wait[N], m_hold[N], m_served[N];

    // Stimulus-side arbiter state, driven from the model so DUT faults do not bend the stimulus.
    bit           rr_mode = 0;
    logic [N-1:0] arb_g, drop, inject, prev_req, prev_rel;
    int           owner, last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic pin(input string name, input logic [N-1:0] d, input logic [N-1:0] m, input logic [N-1:0] exp);
        chk(name, 32'(d), 32'(exp));
        chk({name, "_model"}, 32'(m), 32'(exp));
    endtask

    function automatic logic [23:0] exp_served();
        logic [23:0] r;
        for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'(m_served[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_req = '0; m_busy = '0; m_rel = '0; m_err = '0; m_grace = '0;
        for (int i = 0; i < N; i++) begin
            m_wait[i]   = i + 1;   // enabled idle cycles until the request edge
            m_hold[i]   = 0;
            m_served[i] = 0;
        end
    endtask

    // Advance the model across one clock edge using the inputs applied this cycle.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int f, hl, il;
            bit g, grace;
            f  = int'((m_lfsr >> (4*i)) & 16'h000F);
            hl = cfg_fixed ? ((cfg_hold == 4'd0) ? 1 : int'(cfg_hold)) : (f % HM) + 1;
            il = cfg_fixed ? int'(cfg_idle) : f % IM;
            g  = grant[i];
            grace = m_grace[i];
            m_grace[i] = 1'b0;
            if (m_rel[i]) begin
                m_rel[i] = 1'b0;
                if (m_served[i] < 255) m_served[i]++;
                m_wait[i]  = il + 1;
                m_grace[i] = 1'b1;
            end else if (m_busy[i]) begin
                if (!g) begin
                    m_busy[i] = 1'b0; m_err[i] = 1'b1; m_wait[i] = il + 1;
                end else if (m_hold[i] == 1) begin
                    m_busy[i] = 1'b0; m_rel[i] = 1'b1;
                end else begin
                    m_hold[i]--;
                end
            end else if (m_req[i]) begin
                if (g) begin m_req[i] = 1'b0; m_busy[i] = 1'b1; m_hold[i] = hl; end
            end else begin
                if (g && !grace) m_err[i] = 1'b1;
                if (enable) begin
                    m_wait[i]--;
                    if (m_wait[i] == 0) m_req[i] = 1'b1;
                end
            end
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    // Arbiter: grant follows the previous cycle's request and is held until after release.
    task automatic drive();
        logic [N-1:0] ng;
        if (rr_mode) begin
            if (owner >= 0 && prev_rel[owner]) owner = -1;
            if (owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last + k) % N;
                    if (prev_req[c]) begin owner = c; last = c; break; end
                end
            end
            ng = (owner >= 0) ? N'(1 << owner) : '0;
        end else begin
            ng = prev_req | (arb_g & ~prev_rel);
        end
        arb_g    = ng & ~drop;
        grant    = arb_g | inject;
        prev_req = m_req;
        prev_rel = m_rel;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            cyc++;
            @(negedge clk);
            #1;
            drive();
        end
    endtask

    task automatic do_reset();
        chk_on = 0;
        rst_n  = 1'b0;
        grant = '0; arb_g = '0; drop = '0; inject = '0; prev_req = '0; prev_rel = '0;
        owner = -1; last = N - 1;
        repeat (2) @(negedge clk);
        model_reset();
        cyc    = 0;
        rst_n  = 1'b1;
        chk_on = 1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("request",    32'(request),       32'(m_req));
            chk("busy",       32'(busy),          32'(m_busy));
            chk("release",    32'(release_pulse), 32'(m_rel));
            chk("proto_err",  32'(proto_err),     32'(m_err));
            chk("served_cnt", 32'(served_cnt),    32'(exp_served()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [8:0] trace[TR];
    int run_len[N], gap[N];
    bit in_gap[N];
    int rel_count, sum;

    initial begin
        // Fixed 3/2 timeline and 0/1/2 stagger.
        do_reset();
        step(1); pin("t1_req_c1", request, m_req, 3'b001);
        step(1); pin("t1_req_c2", request, m_req, 3'b011);
        step(1); pin("t1_busy_c3", busy, m_busy, 3'b001);
                 pin("t1_req_c3", request, m_req, 3'b110);
        step(2); pin("t1_busy_c5", busy, m_busy, 3'b111);
        step(1); pin("t1_rel_c6", release_pulse, m_rel, 3'b001);
                 pin("t1_busy_c6", busy, m_busy, 3'b110);
        step(1); pin("t1_rel_c7", release_pulse, m_rel, 3'b010);
                 chk("t1_served0_c7", 32'(served_cnt[7:0]), 32'd1);
        step(1); pin("t1_rel_c8", release_pulse, m_rel, 3'b100);
        step(40);

        // Abort on client 1 and a stray grant to idle client 2.
        do_reset();
        inject = 3'b100;
        step(1);
        inject = '0;
        step(1); pin("t2_err_c2", proto_err, m_err, 3'b100);
        step(2);
        drop = 3'b010;
        step(1); pin("t2_busy_c5", busy, m_busy, 3'b111);
        drop = '0;
        step(1); pin("t2_err_c6", proto_err, m_err, 3'b110);
                 pin("t2_busy_c6", busy, m_busy, 3'b100);
        step(1); pin("t2_rel_c7", release_pulse, m_rel, 3'b000);
        step(2); chk("t2_served1", 32'(served_cnt[15:8]), 32'd0);
                 chk("t2_served0", 32'(served_cnt[7:0]), 32'd1);
        step(30);

        // enable low freezes idle countdowns but not pending requests.
        enable = 1'b0;
        do_reset();
        step(10); pin("t3_req_c10", request, m_req, 3'b000);
        enable = 1'b1;
        step(2); pin("t3_req_c12", request, m_req, 3'b011);
        step(1); pin("t3_req_c13", request, m_req, 3'b110);
        step(10);
        do_reset();
        drop = 3'b111;
        step(4);
        enable = 1'b0;
        step(5); pin("t3_req_hold", request, m_req, 3'b111);
        drop = '0;
        enable = 1'b1;
        step(25);

        // Asynchronous reset in the middle of a hold.
        do_reset();
        step(4);
        chk_on = 0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_rst_request", 32'(request), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_release", 32'(release_pulse), 32'd0);
        chk("t4_rst_err", 32'(proto_err), 32'd0);
        chk("t4_rst_served", 32'(served_cnt), 32'd0);
        do_reset();
        step(1); pin("t4_req_c1", request, m_req, 3'b001);
        step(1); pin("t4_req_c2", request, m_req, 3'b011);
        step(1); pin("t4_req_c3", request, m_req, 3'b110);

        // Zero hold behaves as one cycle; run long enough to saturate the counters.
        cfg_hold = 4'd0;
        cfg_idle = 4'd0;
        do_reset();
        step(3); pin("t5_busy_c3", busy, m_busy, 3'b001);
        step(1); pin("t5_busy_c4", busy, m_busy, 3'b010);
                 pin("t5_rel_c4", release_pulse, m_rel, 3'b001);
        step(1); chk("t5_served0_c5", 32'(served_cnt[7:0]), 32'd1);
        step(1400);
        chk("t5_saturated", 32'(served_cnt), 32'hFFFFFF);

        // Random mode with a round-robin arbiter.
        cfg_fixed = 1'b0;
        rr_mode   = 1;
        do_reset();
        rel_count = 0;
        for (int i = 0; i < N; i++) begin run_len[i] = 0; gap[i] = 0; in_gap[i] = 0; end
        for (int c = 0; c < 2000; c++) begin
            step(1);
            if (c < TR) trace[c] = {m_req, m_busy, m_rel};
            rel_count += $countones(release_pulse);
            for (int i = 0; i < N; i++) begin
                if (busy[i]) begin
                    run_len[i]++;
                end else if (run_len[i] > 0) begin
                    n_cmp++;
                    if (run_len[i] < 1 || run_len[i] > HM) begin
                        n_bad++;
                        $display("FAIL hold_len client %0d: got %0d expected 1..%0d", i, run_len[i], HM);
                    end
                    run_len[i] = 0;
                end
                if (release_pulse[i]) begin
                    gap[i] = 0; in_gap[i] = 1;
                end else if (request[i] && in_gap[i]) begin
                    n_cmp++;
                    if (gap[i] - 1 < 0 || gap[i] - 1 > IM - 1) begin
                        n_bad++;
                        $display("FAIL idle_len client %0d: got %0d expected 0..%0d", i, gap[i] - 1, IM - 1);
                    end
                    in_gap[i] = 0;
                end else if (in_gap[i]) begin
                    gap[i]++;
                end
            end
        end
        sum = int'(served_cnt[7:0]) + int'(served_cnt[15:8]) + int'(served_cnt[23:16]);
        chk("t6_served_sum", 32'(sum), 32'(rel_count));
        chk("t6_no_err", 32'(proto_err), 32'd0);

        // Same seed after re-reset must reproduce the first stretch exactly.
        do_reset();
        for (int c = 0; c < TR; c++) begin
            step(1);
            chk("t6_replay", 32'({request, busy, release_pulse}), 32'(trace[c]));
        end

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
